// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle, with early-out for divide-by-zero and overflow.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nxt;
  logic [2:0]         funct3_r;
  logic [WIDTH-1:0]   opnd_r;   // multiplicand (multiply) or divisor (divide)
  logic [2*WIDTH-1:0] acc_r;    // {product high, multiplier} or {zero, dividend/quotient}
  logic [WIDTH-1:0]   rem_r;
  logic               neg_r;
  logic [CNT_W-1:0]   count_r;
  logic               done_r;
  logic [WIDTH-1:0]   result_r;

  logic               accept_s;
  logic               sa_s;
  logic               sb_s;
  logic               neg_s;
  logic               special_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH-1:0]   special_val_s;

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     rem_sh_s;
  logic               quo_bit_s;
  logic [2*WIDTH-1:0] acc_nxt_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [WIDTH-1:0]   calc_val_s;

  logic               fin_load_s;
  logic [WIDTH-1:0]   fin_val_s;

  assign accept_s = (state_r == IDLE) & start & ~flush;

  // Accept-time decode: operand magnitudes, result sign and early-out results
  always_comb begin
    sa_s          = 1'b0;
    sb_s          = 1'b0;
    special_s     = 1'b0;
    special_val_s = ALL_ZERO;
    case (funct3)
      F_MULH, F_DIV, F_REM: begin
        sa_s = op_a[WIDTH-1];
        sb_s = op_b[WIDTH-1];
      end
      F_MULHSU: begin
        sa_s = op_a[WIDTH-1];
        sb_s = 1'b0;
      end
      default: begin
        sa_s = 1'b0;
        sb_s = 1'b0;
      end
    endcase
    mag_a_s = sa_s ? -op_a : op_a;
    mag_b_s = sb_s ? -op_b : op_b;
    // A remainder follows the dividend's sign; everything else takes the XOR
    neg_s   = (funct3[2] & funct3[1]) ? sa_s : (sa_s ^ sb_s);
    if (funct3[2] && (op_b == ALL_ZERO)) begin
      special_s     = 1'b1;
      special_val_s = funct3[1] ? op_a : ALL_ONES;
    end else if (funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == ALL_ONES)) begin
      special_s     = 1'b1;
      special_val_s = funct3[1] ? ALL_ZERO : MIN_NEG;
    end else begin
      special_s     = 1'b0;
      special_val_s = ALL_ZERO;
    end
  end

  // One iteration of shift-add multiply or restoring divide, plus final sign fix-up
  always_comb begin
    mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    rem_sh_s  = {rem_r, acc_r[WIDTH-1]};
    quo_bit_s = (rem_sh_s >= {1'b0, opnd_r});
    if (funct3_r[2]) begin
      acc_nxt_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], quo_bit_s};
      rem_nxt_s = quo_bit_s ? (rem_sh_s[WIDTH-1:0] - opnd_r) : rem_sh_s[WIDTH-1:0];
    end else begin
      acc_nxt_s = acc_r[0] ? {mul_sum_s, acc_r[WIDTH-1:1]} : {1'b0, acc_r[2*WIDTH-1:1]};
      rem_nxt_s = rem_r;
    end
    prod_s    = neg_r ? -acc_nxt_s : acc_nxt_s;
    quo_s     = neg_r ? -acc_nxt_s[WIDTH-1:0] : acc_nxt_s[WIDTH-1:0];
    rem_fix_s = neg_r ? -rem_nxt_s : rem_nxt_s;
    case (funct3_r)
      F_MUL:                     calc_val_s = prod_s[WIDTH-1:0];
      F_MULH, F_MULHSU, F_MULHU: calc_val_s = prod_s[2*WIDTH-1:WIDTH];
      F_DIV, F_DIVU:             calc_val_s = quo_s;
      F_REM, F_REMU:             calc_val_s = rem_fix_s;
      default:                   calc_val_s = prod_s[WIDTH-1:0];
    endcase
  end

  // Next-state, stall request and result-load decode
  always_comb begin
    state_nxt  = state_r;
    stall_req  = 1'b0;
    fin_load_s = 1'b0;
    fin_val_s  = ALL_ZERO;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          stall_req = 1'b1;
          if (special_s) begin
            state_nxt  = FIN;
            fin_load_s = 1'b1;
            fin_val_s  = special_val_s;
          end else begin
            state_nxt = CALC;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        stall_req = 1'b1;
        if (flush) begin
          state_nxt = IDLE;
        end else if (count_r == LAST_CNT) begin
          state_nxt  = FIN;
          fin_load_s = 1'b1;
          fin_val_s  = calc_val_s;
        end else begin
          state_nxt = CALC;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, done pulse and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      done_r   <= 1'b0;
      result_r <= ALL_ZERO;
    end else begin
      state_r  <= state_nxt;
      done_r   <= fin_load_s;
      result_r <= fin_load_s ? fin_val_s : result_r;
    end
  end

  // Operand latch on accept, then one iteration per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_r <= 3'b000;
      opnd_r   <= ALL_ZERO;
      acc_r    <= {2*WIDTH{1'b0}};
      rem_r    <= ALL_ZERO;
      neg_r    <= 1'b0;
      count_r  <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      funct3_r <= funct3;
      neg_r    <= neg_s;
      rem_r    <= ALL_ZERO;
      count_r  <= {CNT_W{1'b0}};
      if (funct3[2]) begin
        opnd_r <= mag_b_s;
        acc_r  <= {ALL_ZERO, mag_a_s};
      end else begin
        opnd_r <= mag_a_s;
        acc_r  <= {ALL_ZERO, mag_b_s};
      end
    end else if (state_r == CALC) begin
      acc_r   <= acc_nxt_s;
      rem_r   <= rem_nxt_s;
      count_r <= count_r + CNT_ONE;
    end else begin
      acc_r   <= acc_r;
      rem_r   <= rem_r;
      count_r <= count_r;
    end
  end

  assign busy   = (state_r != IDLE);
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a vector table driven through a result
// scoreboard, plus flush, start/flush collision and asynchronous-reset sequences.
module tb_muldiv_unit;

  localparam int W      = 32;
  localparam int BUDGET = 40;
  localparam int LONG   = W + 1;
  localparam int NVEC   = 20;

  logic         clk;
  logic         rst;
  logic         start;
  logic         flush;
  logic [2:0]   funct3;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         stall_req;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  typedef struct {
    string        name;
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t         vecs [NVEC];
  vec_t         v_mul34;
  vec_t         v_mulhsu;
  logic [W-1:0] sb_q [$];
  logic [W-1:0] last_res;
  int           n_chk;
  int           n_pass;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done=1 (result 0x%h), expected done=0", result);
      end else begin
        check("scoreboard_result", result, sb_q.pop_front());
      end
    end
  end

  task automatic run_op(input vec_t v);
    int lat;
    int stall_cnt;
    lat       = 0;
    stall_cnt = 0;
    @(posedge clk); #1;
    start  = 1'b1;
    flush  = 1'b0;
    funct3 = v.f3;
    op_a   = v.a;
    op_b   = v.b;
    sb_q.push_back(v.exp);
    @(negedge clk);
    check({v.name, "_idle_at_accept"}, W'(busy), 32'd0);
    check({v.name, "_held_result"}, result, last_res);
    if (stall_req === 1'b1) stall_cnt++;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= BUDGET && lat == 0; k++) begin
      @(negedge clk);
      if (stall_req === 1'b1) stall_cnt++;
      if (done === 1'b1) lat = k;
    end
    check({v.name, "_latency"}, W'(lat), W'(v.lat));
    check({v.name, "_stall_cycles"}, W'(stall_cnt), W'(v.lat));
    if (lat == 0) sb_q.delete();
    last_res = v.exp;
  endtask

  initial begin
    vecs[0]  = '{"mul_7_m3",        3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LONG};
    vecs[1]  = '{"mulh_min_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LONG};
    vecs[2]  = '{"mulhu_max_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LONG};
    vecs[3]  = '{"div_m7_2",        3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LONG};
    vecs[4]  = '{"rem_m7_2",        3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LONG};
    vecs[5]  = '{"divu_100_7",      3'b101, 32'd100,       32'd7,         32'd14,        LONG};
    vecs[6]  = '{"remu_100_7",      3'b111, 32'd100,       32'd7,         32'd2,         LONG};
    vecs[7]  = '{"divu_by_zero",    3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[8]  = '{"rem_by_zero",     3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};
    vecs[9]  = '{"div_overflow",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[10] = '{"rem_overflow",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[11] = '{"mulh_m1_5",       3'b001, 32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF, LONG};
    vecs[12] = '{"mulhsu_min_max",  3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LONG};
    vecs[13] = '{"div_7_m2",        3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LONG};
    vecs[14] = '{"rem_7_m2",        3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, LONG};
    vecs[15] = '{"divu_max_1",      3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, LONG};
    vecs[16] = '{"remu_by_zero",    3'b111, 32'h0000_1234, 32'd0,         32'h0000_1234, 1};
    vecs[17] = '{"mul_shift",       3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, LONG};
    vecs[18] = '{"mulhu_carry",     3'b011, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, LONG};
    vecs[19] = '{"div_min_1",       3'b100, 32'h8000_0000, 32'd1,         32'h8000_0000, LONG};
    v_mul34  = '{"mul_after_flush", 3'b000, 32'd3,         32'd4,         32'd12,        LONG};
    v_mulhsu = '{"mulhsu_after_rst",3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LONG};

    n_chk    = 0;
    n_pass   = 0;
    last_res = 32'd0;
    rst      = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    funct3   = 3'b000;
    op_a     = 32'd0;
    op_b     = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", W'(busy), 32'd0);
    check("reset_done", W'(done), 32'd0);
    check("reset_stall", W'(stall_req), 32'd0);
    check("reset_result", result, 32'd0);

    for (int i = 0; i < NVEC; i++) run_op(vecs[i]);

    // DIV flushed in its tenth cycle; the following MUL is accepted right after
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_busy_before", W'(busy), 32'd1);
    run_op(v_mul34);

    // start and flush together must not be accepted (divide-by-zero would finish at once)
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = 3'b101; op_a = 32'd9; op_b = 32'd0;
    @(negedge clk);
    check("collide_stall", W'(stall_req), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("collide_busy", W'(busy), 32'd0);
    check("collide_result", result, 32'd12);

    // asynchronous reset in the middle of CALC
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_busy", W'(busy), 32'd0);
    check("midrst_done", W'(done), 32'd0);
    check("midrst_stall", W'(stall_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_res = 32'd0;
    run_op(v_mulhsu);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", W'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
